// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the fetch unit and decoder
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    WAIT   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_e;

  localparam logic [15:0] OP_NOP = 16'h7F80;

  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 8;
  localparam int FIELD_W  = 4;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - control, ROM and decoder handshake bundle of the fetch unit
interface instr_fetch_if #(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 16
);

  logic                   run;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_target;
  logic                   mem_req;
  logic [PC_WIDTH-1:0]    mem_addr;
  logic                   mem_rvalid;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   instr_ready;
  logic [PC_WIDTH-1:0]    fetch_pc;

  modport master (
    input  run, redirect_valid, redirect_target, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instruction, instr_pc, fetch_pc
  );

  modport slave (
    output run, redirect_valid, redirect_target, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instruction, instr_pc, fetch_pc
  );

endinterface

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - 2-entry FIFO of {instruction, pc}; flush overrides push and pop
module instr_queue #(
  parameter int DATA_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  // When full, a push is only taken alongside a pop; the write lands in the slot being freed.
  assign do_push = push && ((count != 2'd2) || pop);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter, single-outstanding ROM fetch and instruction issue
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam int QW = INSTR_WIDTH + PC_WIDTH;

  fetch_state_e        state;
  fetch_state_e        state_nxt;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] req_addr;
  logic [1:0]          count;
  logic [QW-1:0]       head;
  logic                mem_req;
  logic                push;
  logic                pop;
  logic                flush;
  logic                instr_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= '0;
      req_addr <= '0;
    end else begin
      state <= state_nxt;
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_target;
      end else if (mem_req) begin
        fetch_pc <= fetch_pc + PC_WIDTH'(1);
      end
      if (mem_req) begin
        req_addr <= fetch_pc;
      end
    end
  end

  // A request issued in the redirect cycle is already in flight, so its response must be squashed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.run) state_nxt = FETCH;
      end
      FETCH: begin
        if (mem_req)      state_nxt = bus.redirect_valid ? SQUASH : WAIT;
        else if (!bus.run) state_nxt = IDLE;
      end
      WAIT: begin
        if (bus.mem_rvalid)          state_nxt = bus.run ? FETCH : IDLE;
        else if (bus.redirect_valid) state_nxt = SQUASH;
      end
      SQUASH: begin
        if (bus.mem_rvalid) state_nxt = bus.run ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = (state == FETCH) && bus.run && (count < 2'd2);
    push        = (state == WAIT) && bus.mem_rvalid && !bus.redirect_valid;
    flush       = bus.redirect_valid;
    instr_valid = (count != 2'd0) && !bus.redirect_valid;
    pop         = instr_valid && bus.instr_ready;
  end

  instr_queue #(
    .DATA_WIDTH(QW)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .data  ({bus.mem_rdata, req_addr}),
    .count (count),
    .head  (head)
  );

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = instr_valid;
  assign bus.instruction = head[QW-1:PC_WIDTH];
  assign bus.instr_pc    = head[PC_WIDTH-1:0];
  assign bus.fetch_pc    = fetch_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;

  localparam int PCW = 12;
  localparam int IW  = 16;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  ins;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  instr_fetch_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) bus ();

  instr_fetch #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int             n_vec = 0;
  int             n_err = 0;
  logic [IW-1:0]  rom [4096];
  int             lat = 1;
  int             req_count = 0;
  int             rsp_cnt = 0;
  logic [PCW-1:0] rsp_addr = '0;
  logic [PCW-1:0] last_addr = '0;
  exp_t           sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ROM model: samples requests mid-cycle, answers lat cycles later with a one-cycle rvalid.
  always @(negedge clk) begin
    #1;
    bus.mem_rvalid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rom[rsp_addr];
      end
    end
    if (bus.mem_req === 1'b1) begin
      rsp_cnt   = lat;
      rsp_addr  = bus.mem_addr;
      last_addr = bus.mem_addr;
      req_count = req_count + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      chk("issue_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("issue_pc", 32'(bus.instr_pc), 32'(e.pc));
        chk("issue_instr", 32'(bus.instruction), 32'(e.ins));
      end
    end
  end

  task automatic wait_reqs(input int target, input string tag);
    for (int k = 0; k < 40 && req_count < target; k++) begin
      @(negedge clk);
      #3;
    end
    chk(tag, 32'(req_count >= target), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      @(negedge clk);
      #3;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic exp_t mk(input logic [PCW-1:0] pc);
    mk.pc  = pc;
    mk.ins = rom[pc];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int a = 0; a < 4096; a++) rom[a] = 16'hA000 ^ 16'(a * 7);
    rom[0] = 16'h7F88;
    rom[1] = 16'h7F89;
    rom[2] = 16'h0123;
    rom[3] = 16'h6A05;

    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instruction", 32'(bus.instruction), 32'd0);
    chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    chk("rst_fetch_pc", 32'(bus.fetch_pc), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch with 1-cycle ROM.
    lat = 1;
    base = req_count;
    sb.push_back(mk(12'h000));
    sb.push_back(mk(12'h001));
    sb.push_back(mk(12'h002));
    sb.push_back(mk(12'h003));
    bus.instr_ready = 1'b1;
    @(negedge clk); bus.run = 1'b1; #3;
    chk("t1_c0_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk); #3;
    chk("t1_c1_req", 32'(bus.mem_req), 32'd1);
    chk("t1_c1_addr", 32'(bus.mem_addr), 32'h000);
    @(negedge clk); #3;
    chk("t1_c2_req", 32'(bus.mem_req), 32'd0);
    chk("t1_c2_valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk); #3;
    chk("t1_c3_valid", 32'(bus.instr_valid), 32'd1);
    chk("t1_c3_req", 32'(bus.mem_req), 32'd1);
    chk("t1_c3_addr", 32'(bus.mem_addr), 32'h001);
    wait_reqs(base + 4, "t1_reqs");
    @(negedge clk); bus.run = 1'b0;
    drain("t1_drain");
    @(negedge clk); #3;
    chk("t1_idle_req", 32'(bus.mem_req), 32'd0);
    chk("t1_fetch_pc", 32'(bus.fetch_pc), 32'h004);

    // Backpressure: queue fills, fetching stops, head holds.
    do_reset();
    base = req_count;
    sb.push_back(mk(12'h000));
    sb.push_back(mk(12'h001));
    sb.push_back(mk(12'h002));
    @(negedge clk); bus.run = 1'b1; #3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #3;
      if (bus.instr_valid === 1'b1) begin
        chk("t2_hold_instr", 32'(bus.instruction), 32'h7F88);
        chk("t2_hold_pc", 32'(bus.instr_pc), 32'h000);
      end
    end
    chk("t2_req_total", 32'(req_count - base), 32'd2);
    chk("t2_req_stopped", 32'(bus.mem_req), 32'd0);
    chk("t2_valid_held", 32'(bus.instr_valid), 32'd1);
    @(negedge clk); bus.instr_ready = 1'b1;
    wait_reqs(base + 3, "t2_reqs");
    @(negedge clk); bus.run = 1'b0;
    drain("t2_drain");

    // Redirect while WAIT with a 3-cycle ROM.
    do_reset();
    lat = 3;
    base = req_count;
    bus.instr_ready = 1'b1;
    sb.push_back(mk(12'h040));
    @(negedge clk); bus.run = 1'b1;
    wait_reqs(base + 1, "t3_req1");
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 12'h040;
    #3;
    chk("t3_redirect_valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk); bus.redirect_valid = 1'b0;
    wait_reqs(base + 2, "t3_req2");
    chk("t3_new_addr", 32'(last_addr), 32'h040);
    @(negedge clk); bus.run = 1'b0;
    drain("t3_drain");
    chk("t3_fetch_pc", 32'(bus.fetch_pc), 32'h041);

    // Redirect coinciding with pop and rvalid while one entry is queued.
    do_reset();
    lat = 1;
    base = req_count;
    sb.push_back(mk(12'h100));
    @(negedge clk); bus.run = 1'b1;
    wait_reqs(base + 2, "t4_reqs");
    chk("t4_count1_valid", 32'(bus.instr_valid), 32'd1);
    @(negedge clk);
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 12'h100;
    #3;
    chk("t4_redirect_valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk); bus.redirect_valid = 1'b0; #3;
    chk("t4_flushed_valid", 32'(bus.instr_valid), 32'd0);
    chk("t4_req", 32'(bus.mem_req), 32'd1);
    chk("t4_addr", 32'(bus.mem_addr), 32'h100);
    @(negedge clk); bus.run = 1'b0;
    drain("t4_drain");

    // PC wrap from the top of the address space.
    base = req_count;
    sb.push_back(mk(12'hFFF));
    sb.push_back(mk(12'h000));
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 12'hFFF;
    @(negedge clk); bus.redirect_valid = 1'b0; #3;
    chk("t5_fetch_pc", 32'(bus.fetch_pc), 32'hFFF);
    @(negedge clk); bus.run = 1'b1;
    wait_reqs(base + 2, "t5_reqs");
    @(negedge clk); bus.run = 1'b0;
    drain("t5_drain");
    chk("t5_fetch_pc_wrapped", 32'(bus.fetch_pc), 32'h001);

    // Asynchronous reset mid-WAIT; the late response must be ignored.
    lat = 3;
    base = req_count;
    @(negedge clk); bus.run = 1'b1;
    wait_reqs(base + 1, "t6_req1");
    @(negedge clk);
    bus.run = 1'b0;
    reset = 1'b1;
    #3;
    chk("t6_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t6_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6_rst_instruction", 32'(bus.instruction), 32'd0);
    chk("t6_rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    chk("t6_rst_fetch_pc", 32'(bus.fetch_pc), 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      chk("t6_stray_valid", 32'(bus.instr_valid), 32'd0);
      chk("t6_stray_req", 32'(bus.mem_req), 32'd0);
    end
    sb.push_back(mk(12'h000));
    @(negedge clk); bus.run = 1'b1;
    wait_reqs(base + 2, "t6_req2");
    chk("t6_restart_addr", 32'(last_addr), 32'h000);
    @(negedge clk); bus.run = 1'b0;
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch and issue unit: produces the 16-bit instruction word consumed by the control-word decoder (instructionLUT).
- Owns the program counter and issues single-outstanding reads to program ROM.
- Buffers fetched words in a 2-entry queue and presents them on a valid/ready handshake.
- Handles PC redirects (branch/call/return) by flushing the queue and squashing any in-flight response.

Parameters:
- PC_WIDTH, 12, program address width; PC wraps modulo 2^PC_WIDTH.
- INSTR_WIDTH, 16, instruction word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  fetch enable; low stops new requests (queue still drains).
- redirect_valid  in  1  PC redirect strobe (branch taken / call / return).
- redirect_target  in  PC_WIDTH  new fetch address.
- mem_req  out  1  single-cycle program ROM read strobe.
- mem_addr  out  PC_WIDTH  ROM address; meaningful only while mem_req=1.
- mem_rvalid  in  1  read data valid; arrives 1 or more cycles after mem_req.
- mem_rdata  in  INSTR_WIDTH  read data.
- instr_valid  out  1  instruction presented to the decoder.
- instruction  out  INSTR_WIDTH  head-of-queue instruction word.
- instr_pc  out  PC_WIDTH  address of the presented instruction.
- instr_ready  in  1  decoder accepts the instruction this cycle.
- fetch_pc  out  PC_WIDTH  next address to fetch.

Behaviour:
- Reset (async): fetch_pc=0, mem_req=0, instr_valid=0, instruction=0, instr_pc=0, queue empty, state IDLE.
- States:
  - IDLE: go to FETCH when run=1.
  - FETCH: assert mem_req for exactly one cycle with mem_addr=fetch_pc, only if (queue count + outstanding) < 2. Then fetch_pc <= fetch_pc+1 (wraps) and go to WAIT. If there is no space, stay in FETCH with mem_req=0.
  - WAIT: on mem_rvalid, push {mem_rdata, request address}. Then go to FETCH if run=1, else IDLE.
  - SQUASH: on mem_rvalid, discard the data. Then go to FETCH if run=1, else IDLE.
- At most one outstanding request at any time. mem_rvalid outside WAIT/SQUASH is ignored.
- Peak throughput is one instruction per 2 cycles with a 1-cycle ROM.
- Handshake:
  - instr_valid = (count != 0). instruction and instr_pc are taken from registered queue storage, so there is no combinational path from instr_ready to any output.
  - Pop occurs when instr_valid & instr_ready.
  - instruction/instr_pc hold stable while instr_valid=1 and instr_ready=0.
  - Push and pop in the same cycle is allowed when count=1 or 2; count is unchanged.
  - A push into an empty queue is visible the following cycle (rvalid -> instr_valid latency 1).
- Redirect (highest priority):
  - Effects at the next edge: queue flushed, fetch_pc <= redirect_target, any same-cycle pop or push dropped.
  - In the redirect cycle, instr_valid is forced low combinationally.
  - In WAIT without mem_rvalid: go to SQUASH.
  - In WAIT with mem_rvalid, or in SQUASH: data dropped, go to FETCH (or IDLE if run=0).
  - In FETCH or IDLE: the state is unchanged; the next request uses the new target.
  - A redirect in the same cycle as mem_req: that request is already in flight, so go to SQUASH.
- run deasserted mid-WAIT: the pending response is still pushed, then go to IDLE.
- Reset mid-operation: immediate return to reset values. A later stray mem_rvalid is ignored.
- The end-to-end latency figure applies to an empty queue and a 1-cycle ROM, with run rising at cycle 0:
  - mem_req at cycle 1.
  - rvalid at cycle 2.
  - instr_valid at cycle 3.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, FETCH, WAIT, SQUASH.
  - OP_NOP constant 16'h7F80.
  - Opcode field widths (16 / 8 / 4) that the decoder also uses.
- Sub-module instr_queue: 2-entry FIFO of {INSTR_WIDTH + PC_WIDTH} bits.
  - Ports: push, pop, flush, count, head.
  - flush overrides push and pop.

Test Plan:
- Sequential fetch: ROM[0..3]=7F88,7F89,0123,6A05, run=1, ready=1, 1-cycle ROM -> instructions issued in order with instr_pc 0,1,2,3; mem_req every 2nd cycle; first instr_valid at cycle 3.
- Backpressure: ready=0 for 10 cycles -> queue fills to 2; mem_req stops after 2 fetches; instruction holds 7F88; on release, pc 0,1,2 issue with none lost or duplicated.
- Redirect while WAIT: 3-cycle ROM latency, redirect to 0x040 one cycle after mem_req -> stale response dropped; next mem_addr=0x040; first issued instr_pc=0x040.
- Redirect with simultaneous pop and rvalid: count=1, ready=1, rvalid=1, redirect to 0x100 -> instr_valid=0 that cycle; queue empty next cycle; next mem_addr=0x100.
- PC wrap: PC_WIDTH=12, redirect to 0xFFF -> instructions at pc 0xFFF then 0x000.
- Async reset mid-WAIT: pulse reset between edges -> all outputs 0 immediately; the subsequent rvalid is ignored; fetch restarts at pc 0.
